inv_key_stream: RTL and testbench

Iterative AES-128 round-key generator that feeds the inverse cipher datapath. It accepts a cipher key, runs the forward key expansion internally, then streams round keys in decryption order: round Nr first, round 0 last. Output is one 128-bit round key per valid/ready handshake. It replaces the fully unrolled 1408-bit key container on the decryption side of the AES self-test top, trading area for Nr+1 cycles of startup latency.

---
 rtl/inv_key_stream.sv | 151 +++++++++++++++
 tb/tb_inv_key_stream.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_stream.sv
// Iterative AES-128 round-key generator for the inverse cipher: expands the key
// forward one round per cycle, then streams round keys Nr..0 over valid/ready.
module inv_key_stream (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [0:127] key_i,
   output logic [0:127] rk_data_o,
   output logic [3:0]   rk_index_o,
   output logic         rk_valid_o,
   input  logic         rk_ready_i,
   output logic         busy_o,
   output logic         done_o
);

   localparam int         NK       = 4;
   localparam logic [3:0] LAST_RND = 4'(NK + 6);

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

   state_t      state_q, state_d;
   logic [0:31] w0_q, w1_q, w2_q, w3_q;
   logic [0:31] w0_d, w1_d, w2_d, w3_d;
   logic [7:0]  rcon_q, rcon_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
   endfunction

   // Backward step needs the recovered W3 before the S-box; forward uses W3 as held.
   logic [0:31] w3_back, w2_back, w1_back, w0_back;
   logic [0:31] w0_fwd, w1_fwd, w2_fwd, w3_fwd;
   logic [0:31] sub_src, sub_word, t_word;

   assign w3_back  = w3_q ^ w2_q;
   assign w2_back  = w2_q ^ w1_q;
   assign w1_back  = w1_q ^ w0_q;
   assign sub_src  = (state_q == STREAM) ? w3_back : w3_q;
   assign sub_word = {sbox(sub_src[8:15]), sbox(sub_src[16:23]),
                      sbox(sub_src[24:31]), sbox(sub_src[0:7])};
   assign t_word   = sub_word ^ {rcon_q, 24'h000000};
   assign w0_back  = w0_q ^ t_word;

   assign w0_fwd   = w0_q ^ t_word;
   assign w1_fwd   = w1_q ^ w0_fwd;
   assign w2_fwd   = w2_q ^ w1_fwd;
   assign w3_fwd   = w3_q ^ w2_fwd;

   always_comb begin
      state_d = state_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      w3_d    = w3_q;
      rcon_d  = rcon_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               w0_d    = key_i[0:31];
               w1_d    = key_i[32:63];
               w2_d    = key_i[64:95];
               w3_d    = key_i[96:127];
               rcon_d  = 8'h01;
               cnt_d   = 4'd1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            w0_d = w0_fwd;
            w1_d = w1_fwd;
            w2_d = w2_fwd;
            w3_d = w3_fwd;
            // Last round keeps rcon/cnt so the reverse walk starts from round Nr.
            if (cnt_q == LAST_RND) begin
               state_d = STREAM;
            end else begin
               cnt_d  = cnt_q + 4'd1;
               rcon_d = xtime(rcon_q);
            end
         end
         STREAM: begin
            if (rk_ready_i) begin
               if (cnt_q != 4'd0) begin
                  w0_d   = w0_back;
                  w1_d   = w1_back;
                  w2_d   = w2_back;
                  w3_d   = w3_back;
                  cnt_d  = cnt_q - 4'd1;
                  rcon_d = inv_xtime(rcon_q);
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         w0_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         w3_q    <= '0;
         rcon_q  <= 8'h01;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         w3_q    <= w3_d;
         rcon_q  <= rcon_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign rk_valid_o = (state_q == STREAM);
   assign rk_data_o  = rk_valid_o ? {w0_q, w1_q, w2_q, w3_q} : '0;
   assign rk_index_o = rk_valid_o ? cnt_q : 4'd0;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;

endmodule

// File: tb/tb_inv_key_stream.sv
// Directed bench for inv_key_stream using the FIPS-197 AES-128 key schedules.
module tb_inv_key_stream;

   logic         clk = 1'b0;
   logic         reset;
   logic         start_i;
   logic [0:127] key_i;
   logic [0:127] rk_data_o;
   logic [3:0]   rk_index_o;
   logic         rk_valid_o;
   logic         rk_ready_i;
   logic         busy_o;
   logic         done_o;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [0:127] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] KEY_2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic [0:127] fips_rk [0:10];
   logic [0:127] key2_rk [0:10];

   logic [0:127] got_key [0:10];
   logic [3:0]   got_idx [0:10];
   int           got_n, stall_errs, done_cnt, done_at, last_hs;
   logic         busy_at_done, valid_at_done;
   logic [7:0]   lfsr = 8'ha5;

   always #5 clk = ~clk;

   inv_key_stream dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .key_i      (key_i),
      .rk_data_o  (rk_data_o),
      .rk_index_o (rk_index_o),
      .rk_valid_o (rk_valid_o),
      .rk_ready_i (rk_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   function automatic logic [0:127] exp_rk(input bit use_key2, input int rnd);
      return use_key2 ? key2_rk[rnd] : fips_rk[rnd];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [0:127] k);
      start_i = 1'b1;
      key_i   = k;
      tick();
      start_i = 1'b0;
      key_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!rk_valid_o && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Drains one stream; rnd selects LFSR-driven ready instead of ready high.
   task automatic collect(input bit rnd);
      logic [0:127] hold_d;
      logic [3:0]   hold_i;
      bit           stalled;
      bit           r;
      int           post;
      got_n = 0; stall_errs = 0; done_cnt = 0; done_at = -1; last_hs = -1;
      busy_at_done = 1'b1; valid_at_done = 1'b1;
      stalled = 0; post = 0; hold_d = '0; hold_i = '0;
      for (int k = 0; k < 11; k++) begin
         got_key[k] = 'x;
         got_idx[k] = 'x;
      end
      for (int c = 0; c < 300 && post < 4; c++) begin
         if (done_o) begin
            if (done_cnt == 0) begin
               done_at       = c;
               busy_at_done  = busy_o;
               valid_at_done = rk_valid_o;
            end
            done_cnt++;
         end
         if (done_cnt > 0) post++;
         if (rk_valid_o) begin
            if (stalled && (rk_data_o !== hold_d || rk_index_o !== hold_i)) stall_errs++;
            if (rnd) begin
               lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               r    = lfsr[0];
            end else begin
               r = 1'b1;
            end
            rk_ready_i = r;
            if (r) begin
               if (got_n < 11) begin
                  got_key[got_n] = rk_data_o;
                  got_idx[got_n] = rk_index_o;
               end
               got_n++;
               last_hs = c;
               stalled = 0;
            end else begin
               stalled = 1;
               hold_d  = rk_data_o;
               hold_i  = rk_index_o;
            end
         end else if (stalled) begin
            stall_errs++;
            stalled = 0;
         end
         tick();
      end
      rk_ready_i = 1'b1;
   endtask

   task automatic check_stream(input string name, input bit use_key2);
      n_cmp++;
      if (got_n !== 11) begin
         n_bad++;
         $display("FAIL %s_count: got %0d keys want 11", name, got_n);
      end
      for (int k = 0; k < 11; k++) begin
         n_cmp++;
         if (got_key[k] !== exp_rk(use_key2, 10 - k) || got_idx[k] !== 4'(10 - k)) begin
            n_bad++;
            $display("FAIL %s_key%0d: got idx %0d %h want idx %0d %h", name, k,
                     got_idx[k], got_key[k], 10 - k, exp_rk(use_key2, 10 - k));
         end
      end
      n_cmp++;
      if (done_cnt !== 1) begin
         n_bad++;
         $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_cmp++;
      if (rk_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          rk_index_o !== 4'd0 || rk_data_o !== 128'h0) begin
         n_bad++;
         $display("FAIL %s: got valid=%b busy=%b done=%b idx=%0d data=%h want all zero",
                  name, rk_valid_o, busy_o, done_o, rk_index_o, rk_data_o);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b0; key_i = '0; rk_ready_i = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset_state");
      reset = 1'b0;
      tick();
      check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_fips_ready_high();
      int n;
      do_start(KEY_FIPS);
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL fips_busy_after_start: got %b want 1", busy_o);
      end
      wait_valid(n);
      n_cmp++;
      if (n + 1 !== 11) begin
         n_bad++;
         $display("FAIL fips_latency: got %0d cycles want 11", n + 1);
      end
      collect(1'b0);
      check_stream("fips", 1'b0);
      n_cmp++;
      if (done_at !== last_hs + 1 || busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin
         n_bad++;
         $display("FAIL fips_done_timing: got done_at=%0d busy=%b valid=%b want done_at=%0d busy=0 valid=0",
                  done_at, busy_at_done, valid_at_done, last_hs + 1);
      end
   endtask

   task automatic test_random_ready();
      int n;
      do_start(KEY_FIPS);
      wait_valid(n);
      collect(1'b1);
      check_stream("rnd_ready", 1'b0);
      n_cmp++;
      if (stall_errs !== 0) begin
         n_bad++;
         $display("FAIL rnd_ready_stall_stable: got %0d changes while stalled want 0", stall_errs);
      end
   endtask

   task automatic test_key2();
      int n;
      do_start(KEY_2);
      wait_valid(n);
      n_cmp++;
      if (n !== 10 || rk_data_o !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
         n_bad++;
         $display("FAIL key2_first: got wait=%0d %h want wait=10 d014f9a8c9ee2589e13f0cc8b6630ca6",
                  n, rk_data_o);
      end
      collect(1'b0);
      check_stream("key2", 1'b1);
   endtask

   task automatic test_reset_expand();
      int n, bad_seen;
      do_start(KEY_FIPS);
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      check_idle_outputs("reset_expand_outputs");
      reset = 1'b0;
      bad_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rk_valid_o || done_o || busy_o) bad_seen++;
      end
      n_cmp++;
      if (bad_seen !== 0) begin
         n_bad++;
         $display("FAIL reset_expand_quiet: got %0d active cycles want 0", bad_seen);
      end
      do_start(KEY_2);
      wait_valid(n);
      collect(1'b0);
      check_stream("after_reset_expand", 1'b1);
   endtask

   task automatic test_reset_stream();
      int n, bad_seen;
      do_start(KEY_FIPS);
      wait_valid(n);
      rk_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (rk_index_o !== 4'd7 || rk_data_o !== fips_rk[7]) begin
         n_bad++;
         $display("FAIL mid_stream_key: got idx %0d %h want idx 7 %h", rk_index_o, rk_data_o, fips_rk[7]);
      end
      reset = 1'b1;
      tick();
      check_idle_outputs("reset_stream_outputs");
      reset = 1'b0;
      bad_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rk_valid_o || done_o || busy_o) bad_seen++;
      end
      n_cmp++;
      if (bad_seen !== 0) begin
         n_bad++;
         $display("FAIL reset_stream_quiet: got %0d active cycles want 0", bad_seen);
      end
      do_start(KEY_FIPS);
      wait_valid(n);
      collect(1'b0);
      check_stream("after_reset_stream", 1'b0);
   endtask

   task automatic test_start_ignored();
      int n;
      do_start(KEY_FIPS);
      tick();
      tick();
      start_i = 1'b1;
      key_i   = KEY_2;
      tick();
      start_i = 1'b0;
      wait_valid(n);
      n_cmp++;
      if (n !== 7) begin
         n_bad++;
         $display("FAIL start_in_expand_latency: got %0d remaining cycles want 7", n);
      end
      rk_ready_i = 1'b0;
      start_i    = 1'b1;
      key_i      = KEY_2;
      tick();
      start_i    = 1'b0;
      n_cmp++;
      if (rk_valid_o !== 1'b1 || rk_index_o !== 4'd10 || rk_data_o !== fips_rk[10]) begin
         n_bad++;
         $display("FAIL start_in_stream_hold: got valid=%b idx %0d %h want valid=1 idx 10 %h",
                  rk_valid_o, rk_index_o, rk_data_o, fips_rk[10]);
      end
      collect(1'b0);
      check_stream("start_ignored", 1'b0);
   endtask

   task automatic test_back_to_back();
      int n;
      do_start(KEY_FIPS);
      wait_valid(n);
      rk_ready_i = 1'b1;
      n = 0;
      while (!done_o && n < 30) begin
         tick();
         n++;
      end
      n_cmp++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_done_cycle: got done=%b busy=%b want done=1 busy=0", done_o, busy_o);
      end
      start_i = 1'b1;
      key_i   = KEY_2;
      tick();
      start_i = 1'b0;
      n_cmp++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy_o, done_o);
      end
      wait_valid(n);
      n_cmp++;
      if (n !== 10) begin
         n_bad++;
         $display("FAIL b2b_latency: got %0d want 10", n);
      end
      collect(1'b0);
      check_stream("b2b_second", 1'b1);
   endtask

   initial begin
      fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      fips_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      fips_rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      fips_rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      fips_rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      fips_rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      fips_rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      fips_rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      fips_rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      fips_rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      fips_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      key2_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      key2_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      key2_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      key2_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      key2_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      key2_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      key2_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      key2_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      key2_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      key2_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      key2_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      test_reset();
      test_fips_ready_high();
      test_random_ready();
      test_key2();
      test_reset_expand();
      test_reset_stream();
      test_start_ignored();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
